// File: rtl/wb_pkg.sv
// Shared writeback definitions: data/register geometry and the writeback source select.
package wb_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_COUNT = 32;
  localparam int unsigned AW        = 5;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_RSVD = 2'b11
  } wb_sel_e;

endpackage : wb_pkg

// File: rtl/wb_mux.sv
// Writeback source select (ALU / load / PC+4), purely combinational.
// Ports:
//   sel      - writeback source select (wb_sel_e encoding)
//   alu      - ALU result
//   load     - load data
//   pc4      - link value (PC+4)
//   wb_data  - selected writeback value
module wb_mux #(
  parameter int unsigned XLEN = wb_pkg::XLEN
) (
  input  logic [1:0]      sel,
  input  logic [XLEN-1:0] alu,
  input  logic [XLEN-1:0] load,
  input  logic [XLEN-1:0] pc4,
  output logic [XLEN-1:0] wb_data
);

  import wb_pkg::*;

  // Reserved encoding falls back to the ALU result.
  always_comb begin
    wb_data = alu;
    case (wb_sel_e'(sel))
      WB_LOAD: wb_data = load;
      WB_PC4:  wb_data = pc4;
      default: wb_data = alu;
    endcase
  end

endmodule : wb_mux

// File: rtl/wb_regfile.sv
// Writeback stage register file: selects the writeback value, commits it to
// x1..x31, serves two combinational read ports with write-through bypass and
// counts committed writes.
// Ports:
//   clk, resetn                     - clock, asynchronous active-low reset
//   reg_write_in, rd_address_in     - write enable / destination from MEM/WB
//   alu_or_load_or_pc_plus_four_in  - writeback source select
//   alu_result_in, read_data_in,
//   pc_plus_four_in                 - writeback candidates
//   rs1_address/rs1_data,
//   rs2_address/rs2_data            - decode read ports (combinational)
//   wb_data_out                     - selected writeback value (combinational)
//   write_count                     - committed writes to non-zero registers
module wb_regfile #(
  parameter int unsigned XLEN      = wb_pkg::XLEN,
  parameter int unsigned REG_COUNT = wb_pkg::REG_COUNT
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            reg_write_in,
  input  logic [4:0]      rd_address_in,
  input  logic [1:0]      alu_or_load_or_pc_plus_four_in,
  input  logic [XLEN-1:0] alu_result_in,
  input  logic [XLEN-1:0] read_data_in,
  input  logic [XLEN-1:0] pc_plus_four_in,
  input  logic [4:0]      rs1_address,
  input  logic [4:0]      rs2_address,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] wb_data_out,
  output logic [31:0]     write_count
);

  logic [XLEN-1:0] regs [REG_COUNT];
  logic            we;

  wb_mux #(.XLEN(XLEN)) u_wb_mux (
    .sel     (alu_or_load_or_pc_plus_four_in),
    .alu     (alu_result_in),
    .load    (read_data_in),
    .pc4     (pc_plus_four_in),
    .wb_data (wb_data_out)
  );

  // Gating with resetn drops a pending write the instant reset asserts.
  assign we = reg_write_in && (rd_address_in != 5'd0) && resetn;

  // Register array; x0 is never written because we excludes rd == 0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(REG_COUNT); i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[rd_address_in] <= wb_data_out;
    end
  end

  // Committed-write counter, wraps silently.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      write_count <= 32'd0;
    end else if (we) begin
      write_count <= write_count + 32'd1;
    end
  end

  // Read port 1: zero in reset or for x0, bypass on same-cycle write.
  always_comb begin
    rs1_data = '0;
    if (resetn && (rs1_address != 5'd0)) begin
      if (we && (rs1_address == rd_address_in)) begin
        rs1_data = wb_data_out;
      end else begin
        rs1_data = regs[rs1_address];
      end
    end
  end

  // Read port 2: same policy as port 1.
  always_comb begin
    rs2_data = '0;
    if (resetn && (rs2_address != 5'd0)) begin
      if (we && (rs2_address == rd_address_in)) begin
        rs2_data = wb_data_out;
      end else begin
        rs2_data = regs[rs2_address];
      end
    end
  end

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

  logic        clk;
  logic        resetn;
  logic        reg_write_in;
  logic [4:0]  rd_address_in;
  logic [1:0]  sel;
  logic [31:0] alu_result_in;
  logic [31:0] read_data_in;
  logic [31:0] pc_plus_four_in;
  logic [4:0]  rs1_address;
  logic [4:0]  rs2_address;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] wb_data_out;
  logic [31:0] write_count;

  int n_checks;
  int n_pass;

  wb_regfile dut (
    .clk                            (clk),
    .resetn                         (resetn),
    .reg_write_in                   (reg_write_in),
    .rd_address_in                  (rd_address_in),
    .alu_or_load_or_pc_plus_four_in (sel),
    .alu_result_in                  (alu_result_in),
    .read_data_in                   (read_data_in),
    .pc_plus_four_in                (pc_plus_four_in),
    .rs1_address                    (rs1_address),
    .rs2_address                    (rs2_address),
    .rs1_data                       (rs1_data),
    .rs2_data                       (rs2_data),
    .wb_data_out                    (wb_data_out),
    .write_count                    (write_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [31:0] alu;
    logic [31:0] load;
    logic [31:0] pc4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] exp_rs1;
    logic [31:0] exp_rs2;
    logic [31:0] exp_wb;
    logic [31:0] exp_cnt;   // write_count after the edge
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  task automatic drive(input logic we, input logic [4:0] rd, input logic [1:0] s,
                       input logic [31:0] alu, input logic [31:0] load, input logic [31:0] pc4,
                       input logic [4:0] r1, input logic [4:0] r2);
    reg_write_in    = we;
    rd_address_in   = rd;
    sel             = s;
    alu_result_in   = alu;
    read_data_in    = load;
    pc_plus_four_in = pc4;
    rs1_address     = r1;
    rs2_address     = r2;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    resetn   = 1'b0;
    drive(1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);

    //          we    rd     sel    alu           load          pc4           rs1    rs2    exp_rs1       exp_rs2       exp_wb        cnt
    vecs[0] = '{1'b1, 5'd5,  2'b00, 32'hDEADBEEF, 32'h0,        32'h0,        5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'd1};
    vecs[1] = '{1'b0, 5'd5,  2'b00, 32'h0,        32'h0,        32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        32'd1};
    vecs[2] = '{1'b1, 5'd7,  2'b01, 32'h111,      32'h12345678, 32'h0,        5'd7,  5'd7,  32'h12345678, 32'h12345678, 32'h12345678, 32'd2};
    vecs[3] = '{1'b1, 5'd8,  2'b10, 32'h222,      32'h333,      32'h00000104, 5'd8,  5'd7,  32'h00000104, 32'h12345678, 32'h00000104, 32'd3};
    vecs[4] = '{1'b1, 5'd10, 2'b11, 32'hCAFE0001, 32'h444,      32'h555,      5'd10, 5'd8,  32'hCAFE0001, 32'h00000104, 32'hCAFE0001, 32'd4};
    vecs[5] = '{1'b1, 5'd0,  2'b00, 32'hFFFFFFFF, 32'h0,        32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        32'hFFFFFFFF, 32'd4};
    vecs[6] = '{1'b0, 5'd0,  2'b00, 32'hFFFFFFFF, 32'h0,        32'h0,        5'd0,  5'd10, 32'h0,        32'hCAFE0001, 32'hFFFFFFFF, 32'd4};
    vecs[7] = '{1'b0, 5'd5,  2'b00, 32'h99,       32'h0,        32'h0,        5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        32'h99,       32'd4};
    vecs[8] = '{1'b1, 5'd5,  2'b00, 32'h55,       32'h0,        32'h0,        5'd5,  5'd10, 32'h55,       32'hCAFE0001, 32'h55,       32'd5};
    vecs[9] = '{1'b0, 5'd0,  2'b01, 32'h0,        32'h77,       32'h0,        5'd5,  5'd7,  32'h55,       32'h12345678, 32'h77,       32'd5};

    // Reset held over a couple of edges, then read every address.
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    for (int a = 0; a < 32; a++) begin
      rs1_address = 5'(a);
      rs2_address = 5'(31 - a);
      #1;
      check($sformatf("reset_rs1[%0d]", a), rs1_data, 32'h0);
      check($sformatf("reset_rs2[%0d]", 31 - a), rs2_data, 32'h0);
    end
    check("reset_count", write_count, 32'd0);

    // Table-driven vectors: combinational outputs mid-cycle, counter after the edge.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(vecs[i].we, vecs[i].rd, vecs[i].sel, vecs[i].alu, vecs[i].load,
            vecs[i].pc4, vecs[i].rs1, vecs[i].rs2);
      #1;
      check($sformatf("v%0d_rs1", i), rs1_data, vecs[i].exp_rs1);
      check($sformatf("v%0d_rs2", i), rs2_data, vecs[i].exp_rs2);
      check($sformatf("v%0d_wb", i), wb_data_out, vecs[i].exp_wb);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_cnt", i), write_count, vecs[i].exp_cnt);
    end

    // Reset asserted mid-cycle while a write to x9 is pending.
    @(negedge clk);
    drive(1'b1, 5'd9, 2'b00, 32'hA5A5A5A5, 32'h0, 32'h0, 5'd9, 5'd9);
    #1;
    check("pre_rst_bypass", rs1_data, 32'hA5A5A5A5);
    #1;
    resetn = 1'b0;
    #1;
    check("rst_rs1_zero", rs1_data, 32'h0);
    check("rst_rs2_zero", rs2_data, 32'h0);
    check("rst_wb_live", wb_data_out, 32'hA5A5A5A5);
    check("rst_count", write_count, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reg_write_in = 1'b0;
    resetn = 1'b1;
    #1;
    check("post_rst_x9", rs1_data, 32'h0);
    @(posedge clk);
    #1;
    check("post_rst_x9_next", rs1_data, 32'h0);
    rs2_address = 5'd5;
    #1;
    check("post_rst_x5", rs2_data, 32'h0);

    // Counter wrap: preload to all-ones, then one more commit.
    @(negedge clk);
    force dut.write_count = 32'hFFFFFFFF;
    #1;
    release dut.write_count;
    #1;
    check("preload_count", write_count, 32'hFFFFFFFF);
    drive(1'b1, 5'd12, 2'b00, 32'h1234ABCD, 32'h0, 32'h0, 5'd0, 5'd0);
    @(posedge clk);
    #1;
    check("wrap_count", write_count, 32'd0);
    @(negedge clk);
    drive(1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd12, 5'd12);
    #1;
    check("wrap_x12_rs1", rs1_data, 32'h1234ABCD);
    check("wrap_x12_rs2", rs2_data, 32'h1234ABCD);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_wb_regfile
